// File: rtl/seq_alu_if.sv
// Request/response bundle between a client and the sequential ALU.
// The client drives start/op/a/b; the unit returns status, result and HI/LO.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             ovf;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  ready, done, y, zero, ovf, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output ready, done, y, zero, ovf, div0, hi, lo
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential MIPS-style ALU: single-cycle logic/arith ops, iterative
// shift-add multiply and restoring divide writing the HI/LO pair.
//
// state  | meaning
// S_IDLE | ready; single-cycle ops complete here
// S_MUL  | one shift-add step per cycle, WIDTH steps
// S_DIV  | one restoring-divide step per cycle, WIDTH steps
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOR   = 4'h5;
  localparam logic [3:0] OP_SLT   = 4'h6;
  localparam logic [3:0] OP_SLTU  = 4'h7;
  localparam logic [3:0] OP_MULT  = 4'h8;
  localparam logic [3:0] OP_MULTU = 4'h9;
  localparam logic [3:0] OP_DIV   = 4'hA;
  localparam logic [3:0] OP_DIVU  = 4'hB;
  localparam logic [3:0] OP_MFHI  = 4'hC;
  localparam logic [3:0] OP_MFLO  = 4'hD;
  localparam logic [3:0] OP_MTHI  = 4'hE;
  localparam logic [3:0] OP_MTLO  = 4'hF;

  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   opnd;
  logic               neg_lo;
  logic               neg_hi;
  logic               div_ovf;

  logic               done_r;
  logic               zero_r;
  logic               ovf_r;
  logic               div0_r;
  logic [WIDTH-1:0]   y_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               sgn;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_ovf;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;

  // Signed mul/div run on magnitudes; the sign is restored on the last step.
  assign sgn   = ~bus.op[0];
  assign a_neg = sgn & bus.a[WIDTH-1];
  assign b_neg = sgn & bus.b[WIDTH-1];
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;

  assign sum  = bus.a + bus.b;
  assign diff = bus.a - bus.b;

  always_comb begin
    alu_y   = '0;
    alu_ovf = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_y   = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y   = diff;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_y = bus.a & bus.b;
      OP_OR:   alu_y = bus.a | bus.b;
      OP_XOR:  alu_y = bus.a ^ bus.b;
      OP_NOR:  alu_y = ~(bus.a | bus.b);
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_MFHI: alu_y = hi_r;
      OP_MFLO: alu_y = lo_r;
      OP_MTHI: alu_y = bus.a;
      OP_MTLO: alu_y = bus.a;
      default: alu_y = '0;
    endcase
  end

  // p holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  assign mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opnd} : '0);
  assign mul_next  = {mul_sum, p[WIDTH-1:1]};
  assign mul_res   = neg_lo ? -mul_next : mul_next;

  assign div_trial = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]} - {1'b0, opnd};
  assign div_next  = div_trial[WIDTH] ? {p[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  assign quo_res   = neg_lo ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
  assign rem_res   = neg_hi ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      p       <= '0;
      opnd    <= '0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      div_ovf <= 1'b0;
      done_r  <= 1'b0;
      zero_r  <= 1'b0;
      ovf_r   <= 1'b0;
      div0_r  <= 1'b0;
      y_r     <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
                state  <= S_MUL;
                cnt    <= CNT_LOAD;
                p      <= {{WIDTH{1'b0}}, a_mag};
                opnd   <= b_mag;
                neg_lo <= a_neg ^ b_neg;
              end
              OP_DIV, OP_DIVU: begin
                if (bus.b == '0) begin
                  done_r <= 1'b1;
                  y_r    <= lo_r;
                  zero_r <= (lo_r == '0);
                  ovf_r  <= 1'b0;
                  div0_r <= 1'b1;
                end else begin
                  state   <= S_DIV;
                  cnt     <= CNT_LOAD;
                  p       <= {{WIDTH{1'b0}}, a_mag};
                  opnd    <= b_mag;
                  neg_lo  <= a_neg ^ b_neg;
                  neg_hi  <= a_neg;
                  div_ovf <= sgn && (bus.a == MIN_NEG) && (&bus.b);
                end
              end
              default: begin
                done_r <= 1'b1;
                y_r    <= alu_y;
                zero_r <= (alu_y == '0);
                ovf_r  <= alu_ovf;
                div0_r <= 1'b0;
                if (bus.op == OP_MTHI) hi_r <= bus.a;
                if (bus.op == OP_MTLO) lo_r <= bus.a;
              end
            endcase
          end
        end
        S_MUL: begin
          p   <= mul_next;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state  <= S_IDLE;
            done_r <= 1'b1;
            hi_r   <= mul_res[2*WIDTH-1:WIDTH];
            lo_r   <= mul_res[WIDTH-1:0];
            y_r    <= mul_res[WIDTH-1:0];
            zero_r <= (mul_res == '0);
            ovf_r  <= 1'b0;
            div0_r <= 1'b0;
          end
        end
        S_DIV: begin
          p   <= div_next;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state  <= S_IDLE;
            done_r <= 1'b1;
            hi_r   <= rem_res;
            lo_r   <= quo_res;
            y_r    <= quo_res;
            zero_r <= (quo_res == '0);
            ovf_r  <= div_ovf;
            div0_r <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready = (state == S_IDLE);
  assign bus.done  = done_r;
  assign bus.y     = y_r;
  assign bus.zero  = zero_r;
  assign bus.ovf   = ovf_r;
  assign bus.div0  = div0_r;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus random ops
// compared against a plain-arithmetic reference model of the HI/LO machine.
module tb_seq_alu;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;

  seq_alu_if #(.WIDTH(WIDTH)) bus ();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  // Reference model: updates m_hi/m_lo and returns the expected outputs.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] ey, output logic ez, output logic eo,
                          output logic ed, output int elat);
    longint sa, sb, s;
    logic [63:0] pr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    pr = '0;
    ey = '0; eo = 1'b0; ed = 1'b0; elat = 1;
    case (op)
      4'h0: begin s = sa + sb; ey = a + b; eo = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'h1: begin s = sa - sb; ey = a - b; eo = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'h2: ey = a & b;
      4'h3: ey = a | b;
      4'h4: ey = a ^ b;
      4'h5: ey = ~(a | b);
      4'h6: ey = (sa < sb) ? 32'd1 : 32'd0;
      4'h7: ey = (a < b) ? 32'd1 : 32'd0;
      4'h8, 4'h9: begin
        if (op == 4'h8) pr = 64'(sa * sb);
        else pr = {32'b0, a} * {32'b0, b};
        m_hi = pr[63:32]; m_lo = pr[31:0]; ey = m_lo; elat = WIDTH + 1;
      end
      4'hA, 4'hB: begin
        if (b == 32'd0) begin
          ed = 1'b1;
        end else begin
          elat = WIDTH + 1;
          if (op == 4'hB) begin
            m_lo = a / b; m_hi = a % b;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_lo = 32'h8000_0000; m_hi = 32'd0; eo = 1'b1;
          end else begin
            m_lo = 32'(sa / sb); m_hi = 32'(sa % sb);
          end
        end
        ey = m_lo;
      end
      4'hC: ey = m_hi;
      4'hD: ey = m_lo;
      4'hE: begin m_hi = a; ey = a; end
      default: begin m_lo = a; ey = a; end
    endcase
    ez = (op == 4'h8 || op == 4'h9) ? (pr == 64'd0) : (ey == 32'd0);
  endtask

  // Drives one request once ready, scrambles operands while busy, and
  // returns the cycles until done (or -1 if done never came).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    int guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < WIDTH + 8) begin
      bus.a = $urandom; bus.b = $urandom; bus.op = 4'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.done) lat = -1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.ready); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_vec++; if (bus.y !== 32'd0) begin n_err++; $display("FAIL reset_y got %h want 0", bus.y); end
    n_vec++; if ({bus.zero, bus.ovf, bus.div0} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {bus.zero, bus.ovf, bus.div0}); end
    n_vec++; if ({bus.hi, bus.lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo got %h want 0", {bus.hi, bus.lo}); end
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_spec_examples();
    logic [31:0] ey, hi_before; logic ez, eo, ed; int elat, lat;
    model_op(4'h0, 32'h7FFF_FFFF, 32'd1, ey, ez, eo, ed, elat);
    issue(4'h0, 32'h7FFF_FFFF, 32'd1, lat);
    n_vec++; if (lat !== 1 || bus.y !== 32'h8000_0000 || bus.ovf !== 1'b1 || bus.zero !== 1'b0) begin
      n_err++; $display("FAIL add_ovf got lat=%0d y=%h ovf=%b zero=%b want lat=1 y=80000000 ovf=1 zero=0", lat, bus.y, bus.ovf, bus.zero); end

    model_op(4'h8, 32'hFFFF_FFFD, 32'd5, ey, ez, eo, ed, elat);
    issue(4'h8, 32'hFFFF_FFFD, 32'd5, lat);
    n_vec++; if (lat !== 33 || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1 || bus.y !== 32'hFFFF_FFF1) begin
      n_err++; $display("FAIL mult_neg got lat=%0d hi=%h lo=%h y=%h want 33 ffffffff fffffff1 fffffff1", lat, bus.hi, bus.lo, bus.y); end

    model_op(4'hA, 32'hFFFF_FFF9, 32'd2, ey, ez, eo, ed, elat);
    issue(4'hA, 32'hFFFF_FFF9, 32'd2, lat);
    n_vec++; if (lat !== 33 || bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL div_neg got lat=%0d lo=%h hi=%h want 33 fffffffd ffffffff", lat, bus.lo, bus.hi); end
    model_op(4'hC, 32'd0, 32'd0, ey, ez, eo, ed, elat);
    issue(4'hC, 32'd0, 32'd0, lat);
    n_vec++; if (lat !== 1 || bus.y !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL mfhi got lat=%0d y=%h want 1 ffffffff", lat, bus.y); end

    model_op(4'hF, 32'h1234, 32'd0, ey, ez, eo, ed, elat);
    issue(4'hF, 32'h1234, 32'd0, lat);
    hi_before = bus.hi;
    model_op(4'hB, $urandom, 32'd0, ey, ez, eo, ed, elat);
    issue(4'hB, 32'hDEAD, 32'd0, lat);
    n_vec++; if (lat !== 1 || bus.div0 !== 1'b1 || bus.lo !== 32'h1234 || bus.y !== 32'h1234 || bus.hi !== hi_before) begin
      n_err++; $display("FAIL divu_zero got lat=%0d div0=%b lo=%h y=%h hi=%h want 1 1 1234 1234 %h", lat, bus.div0, bus.lo, bus.y, bus.hi, hi_before); end

    model_op(4'hA, 32'h8000_0000, 32'hFFFF_FFFF, ey, ez, eo, ed, elat);
    issue(4'hA, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    n_vec++; if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0 || bus.ovf !== 1'b1 || bus.div0 !== 1'b0) begin
      n_err++; $display("FAIL div_minneg got lo=%h hi=%h ovf=%b div0=%b want 80000000 0 1 0", bus.lo, bus.hi, bus.ovf, bus.div0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ey; logic ez, eo, ed; int elat, lat;
    logic [31:0] ma, mb;
    ma = $urandom; mb = $urandom;
    model_op(4'h8, ma, mb, ey, ez, eo, ed, elat);
    issue(4'h8, ma, mb, lat);
    n_vec++; if (lat !== elat || bus.hi !== m_hi || bus.lo !== m_lo) begin
      n_err++; $display("FAIL b2b_mult got lat=%0d hi=%h lo=%h want %0d %h %h", lat, bus.hi, bus.lo, elat, m_hi, m_lo); end
    @(negedge clk);
    n_vec++; if (bus.done !== 1'b1 || bus.ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_window got done=%b ready=%b want 1 1", bus.done, bus.ready); end
    bus.start = 1'b1; bus.op = 4'h1; bus.a = 32'd5; bus.b = 32'd5;
    model_op(4'h1, 32'd5, 32'd5, ey, ez, eo, ed, elat);
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_vec++; if (bus.done !== 1'b1 || bus.y !== 32'd0 || bus.zero !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo) begin
      n_err++; $display("FAIL b2b_sub got done=%b y=%h zero=%b hi=%h lo=%h want 1 0 1 %h %h", bus.done, bus.y, bus.zero, bus.hi, bus.lo, m_hi, m_lo); end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus.done !== 1'b0 || bus.y !== 32'd0 || bus.zero !== 1'b1) begin
      n_err++; $display("FAIL hold got done=%b y=%h zero=%b want 0 0 1", bus.done, bus.y, bus.zero); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, ey; logic [3:0] op; logic ez, eo, ed; int elat, lat;
    for (int i = 0; i < 160; i++) begin
      op = 4'($urandom_range(0, 15));
      a = pick(); b = pick();
      model_op(op, a, b, ey, ez, eo, ed, elat);
      issue(op, a, b, lat);
      n_vec++; if (lat !== elat) begin n_err++; $display("FAIL rnd%0d_lat op=%h got %0d want %0d", i, op, lat, elat); end
      n_vec++; if (bus.y !== ey) begin n_err++; $display("FAIL rnd%0d_y op=%h a=%h b=%h got %h want %h", i, op, a, b, bus.y, ey); end
      n_vec++; if ({bus.zero, bus.ovf, bus.div0} !== {ez, eo, ed}) begin
        n_err++; $display("FAIL rnd%0d_flags op=%h a=%h b=%h got %b want %b", i, op, a, b, {bus.zero, bus.ovf, bus.div0}, {ez, eo, ed}); end
      n_vec++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin
        n_err++; $display("FAIL rnd%0d_hilo op=%h a=%h b=%h got %h_%h want %h_%h", i, op, a, b, bus.hi, bus.lo, m_hi, m_lo); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] ey; logic ez, eo, ed; int elat, lat, seen;
    model_op(4'hE, 32'hA5A5_0001, 32'd0, ey, ez, eo, ed, elat);
    issue(4'hE, 32'hA5A5_0001, 32'd0, lat);
    model_op(4'hF, 32'h5A5A_0002, 32'd0, ey, ez, eo, ed, elat);
    issue(4'hF, 32'h5A5A_0002, 32'd0, lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'h9; bus.a = $urandom | 32'd1; bus.b = $urandom | 32'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'h0; bus.a = 32'd1; bus.b = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    n_vec++; if (bus.ready !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL busy_start got ready=%b done=%b want 0 0", bus.ready, bus.done); end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    n_vec++; if (bus.ready !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.done !== 1'b0 || bus.y !== 32'd0) begin
      n_err++; $display("FAIL abort got ready=%b hi=%h lo=%h done=%b y=%h want 1 0 0 0 0", bus.ready, bus.hi, bus.lo, bus.done, bus.y); end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL abort_nodone got %0d done pulses want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_spec_examples();
    test_back_to_back();
    test_random();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
